prbs_checker: RTL and testbench

//  Receive-side companion of the PRBS9 source: self-synchronises to the incoming
//  x^9+x^5+1 (XNOR-form) bit stream after QPSK demapping, then counts bits and
//  bit errors for BER measurement. Sits after the slicer/demapper on the RX path.

---
 rtl/prbs_pkg.sv | 21 ++
 rtl/prbs_sat_cnt.sv | 38 +++
 rtl/prbs_checker.sv | 178 +++++++++++++++++
 tb/tb_prbs_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// PRBS9 shared definitions: register length, feedback taps, XNOR constant and
// the receive-checker state encoding. Shared with the PRBS source.
package prbs_pkg;

    localparam int   PRBS_LEN = 9;
    localparam int   TAP_A    = 0;
    localparam int   TAP_B    = 4;
    localparam logic XNOR_C   = 1'b1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_t;

    // Next-bit prediction from the last PRBS_LEN bits (r[0] is the oldest).
    function automatic logic prbs_pred(input logic [PRBS_LEN-1:0] r);
        return r[TAP_A] ^ r[TAP_B] ^ XNOR_C;
    endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear has priority over
// increment). Holds at SAT_VAL instead of wrapping.
module prbs_sat_cnt #(
    parameter int             W       = 32,
    parameter logic [W-1:0]   SAT_VAL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until the saturation value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != SAT_VAL)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// PRBS9 (x^9+x^5+1, XNOR form) receive checker: self-synchronises to the
// demapped bit stream, then counts checked bits and bit errors for BER.
// Optional macro PRBS_CHK_RESYNC_EN adds a loss-of-lock window that drops
// back to acquisition when too many errors occur within one window.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int LOCK_CNT = 16
`ifdef PRBS_CHK_RESYNC_EN
    ,
    parameter int LOSS_WIN = 64,
    parameter int LOSS_THR = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             bit_in,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    // One counter serves both LOAD (bits loaded) and VERIFY (matches in a row).
    localparam int SEQ_MAX = (LOCK_CNT > PRBS_LEN) ? LOCK_CNT : PRBS_LEN;
    localparam int CW      = $clog2(SEQ_MAX + 1);

    prbs_state_t         state_q,  state_d;
    logic [PRBS_LEN-1:0] r_q,      r_d;
    logic [CW-1:0]       cnt_q,    cnt_d;
    logic                locked_q, locked_d;
    logic                err_q,    err_d;
    logic                pred;
    logic                mismatch;
    logic                bc_inc;
    logic                ec_inc;

`ifdef PRBS_CHK_RESYNC_EN
    localparam int WW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
    localparam int EW = $clog2(LOSS_THR + 1);

    logic [WW-1:0] win_cnt_q, win_cnt_d;
    logic [EW-1:0] win_err_q, win_err_d;
    logic [EW-1:0] win_err_n;
`endif

    assign pred     = prbs_pred(r_q);
    assign mismatch = bit_in ^ pred;

    // Next-state logic: acquisition FSM, shift register, error pulse, window.
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        bc_inc   = 1'b0;
        ec_inc   = 1'b0;
`ifdef PRBS_CHK_RESYNC_EN
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        win_err_n = win_err_q + EW'(mismatch);
`endif
        if (enable) begin
            case (state_q)
                ST_LOAD: begin
                    r_d = {bit_in, r_q[PRBS_LEN-1:1]};
                    if (cnt_q == CW'(PRBS_LEN - 1)) begin
                        state_d = ST_VERIFY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_VERIFY: begin
                    // A miss leaves the received bits in r, so re-sync is implicit.
                    r_d = {bit_in, r_q[PRBS_LEN-1:1]};
                    if (mismatch) begin
                        cnt_d = '0;
                    end else if (cnt_q == CW'(LOCK_CNT - 1)) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                        cnt_d    = '0;
`ifdef PRBS_CHK_RESYNC_EN
                        win_cnt_d = '0;
                        win_err_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction so one channel error costs one count.
                    r_d    = {pred, r_q[PRBS_LEN-1:1]};
                    bc_inc = 1'b1;
                    if (mismatch) begin
                        err_d  = 1'b1;
                        ec_inc = 1'b1;
                    end
`ifdef PRBS_CHK_RESYNC_EN
                    // Loss takes precedence over the window-end clear.
                    if (win_err_n == EW'(LOSS_THR)) begin
                        state_d   = ST_LOAD;
                        locked_d  = 1'b0;
                        cnt_d     = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == WW'(LOSS_WIN - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WW'(1);
                        win_err_d = win_err_n;
                    end
`endif
                end
                default: begin
                    state_d  = ST_LOAD;
                    cnt_d    = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // Checker state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            r_q      <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

`ifdef PRBS_CHK_RESYNC_EN
    // Loss-of-lock window registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
        end
    end
`endif

    prbs_sat_cnt #(.W(CNT_W)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bc_inc),
        .clr (clear),
        .cnt (bit_count)
    );

    prbs_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ec_inc),
        .clr (clear),
        .cnt (err_count)
    );

    assign locked = locked_q;
    assign err    = err_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: drives the seed-0 PRBS9 stream with optional bit
// flips, random enable gaps and clears, and checks two instances (full width
// and an 8-bit counter build for saturation) against a count-level model.
module tb_prbs_checker;

    localparam int PER = 511;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        bit_in = 1'b0;
    logic        clear = 1'b0;
    logic        locked, err;
    logic [31:0] bit_count, err_count;
    logic        locked_s, err_s;
    logic [7:0]  bit_count_s, err_count_s;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .bit_in    (bit_in),
        .clear     (clear),
        .locked    (locked),
        .err       (err),
        .bit_count (bit_count),
        .err_count (err_count)
    );

    prbs_checker #(.CNT_W(8)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .bit_in    (bit_in),
        .clear     (clear),
        .locked    (locked_s),
        .err       (err_s),
        .bit_count (bit_count_s),
        .err_count (err_count_s)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int err_pulses = 0;
    bit cmp_on = 1'b0;

    bit seq [PER + 9];
    int sidx = 0;

    // Model: clean bits needed to lock, then counts of checked bits/errors.
    int     m_acq;
    bit     m_locked;
    longint m_bc, m_ec;
    bit     m_err;
    int     m_wpos, m_werr;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_acq = 0; m_locked = 0; m_bc = 0; m_ec = 0; m_err = 0;
        m_wpos = 0; m_werr = 0;
    endtask

    task automatic model_bit(input bit en, input bit fl, input bit clr);
        m_err = 0;
        if (en) begin
            if (!m_locked) begin
                m_acq++;
                if (m_acq == 9 + 16) begin
                    m_locked = 1; m_wpos = 0; m_werr = 0;
                end
            end else begin
                m_bc++;
                if (fl) begin m_err = 1; m_ec++; end
`ifdef PRBS_CHK_RESYNC_EN
                if (fl) m_werr++;
                if (m_werr == 8) begin
                    m_locked = 0; m_acq = 0;
                end else if (m_wpos == 63) begin
                    m_wpos = 0; m_werr = 0;
                end else begin
                    m_wpos++;
                end
`endif
            end
        end
        if (clr) begin m_bc = 0; m_ec = 0; end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(input bit en, input bit fl, input bit clr);
        bit f;
        f = fl && en && m_locked;
        enable = en;
        clear  = clr;
        bit_in = en ? (seq[sidx % PER] ^ f) : 1'($urandom);
        @(posedge clk);
        model_bit(en, f, clr);
        if (en) sidx++;
        #1;
    endtask

    task automatic do_reset();
        enable = 0; clear = 0;
        rst = 1;
        model_reset();
        #1;
        chk("rst_locked", longint'(locked), 0);
        chk("rst_err", longint'(err), 0);
        chk("rst_bit_count", longint'(bit_count), 0);
        chk("rst_err_count", longint'(err_count), 0);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    // Per-cycle compare of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                if (err) err_pulses++;
                chk("locked", longint'(locked), longint'(m_locked));
                chk("err", longint'(err), longint'(m_err));
                chk("bit_count", longint'(bit_count), sat(m_bc, 64'hFFFF_FFFF));
                chk("err_count", longint'(err_count), sat(m_ec, 64'hFFFF_FFFF));
                chk("locked_s", longint'(locked_s), longint'(m_locked));
                chk("err_s", longint'(err_s), longint'(m_err));
                chk("bit_count_s", longint'(bit_count_s), sat(m_bc, 255));
                chk("err_count_s", longint'(err_count_s), sat(m_ec, 255));
            end
        end
    end

    initial begin
        int s;
        int n;
        // Reference sequence from the recurrence, seed 0.
        for (int i = 0; i < PER + 9; i++)
            seq[i] = (i < 9) ? 1'b0 : ~(seq[i-9] ^ seq[i-5]);
        s = 0;
        for (int i = 0; i < 9; i++) s += int'(seq[i]);
        chk("seq_prefix_zeros", s, 0);
        chk("seq9", longint'(seq[9]), 1);
        chk("seq14", longint'(seq[14]), 0);
        s = 0;
        for (int i = 0; i < 9; i++) s += int'(seq[PER + i] != seq[i]);
        chk("seq_period", s, 0);

        // Test 1: acquisition and 1000 clean bits.
        do_reset();
        cmp_on = 1;
        for (int i = 0; i < 24; i++) step(1, 0, 0);
        chk("acq24_locked", longint'(locked), 0);
        step(1, 0, 0);
        chk("acq25_locked", longint'(locked), 1);
        for (int i = 0; i < 1000; i++) step(1, 0, 0);
        chk("t1_bit_count", longint'(bit_count), 1000);
        chk("t1_err_count", longint'(err_count), 0);
        chk("t1_err_pulses", err_pulses, 0);
        chk("t1_sat_count", longint'(bit_count_s), 255);
        $display("t1 lock+1000 bits: bit_count=%0d err_count=%0d", bit_count, err_count);

        // Test 2: single flipped bit.
        step(1, 1, 0);
        chk("t2_err_pulse", longint'(err), 1);
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        chk("t2_err_count", longint'(err_count), 1);
        chk("t2_err_pulses", err_pulses, 1);
        chk("t2_locked", longint'(locked), 1);
        $display("t2 single flip: err_count=%0d locked=%0d", err_count, locked);

        // Test 5: clear coincident with an enabled bit.
        step(1, 0, 1);
        chk("t5_clr_bc", longint'(bit_count), 0);
        chk("t5_clr_ec", longint'(err_count), 0);
        step(1, 0, 0);
        chk("t5_next_bc", longint'(bit_count), 1);
        $display("t5 clear: bit_count=%0d", bit_count);

        // Test 3 (+ mid-lock reset): eight flips right after lock.
        do_reset();
        for (int i = 0; i < 25; i++) step(1, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 0);
        chk("t3_err8", longint'(err), 1);
        chk("t3_ec", longint'(err_count), 8);
        chk("t3_bc", longint'(bit_count), 8);
`ifdef PRBS_CHK_RESYNC_EN
        chk("t3_lost", longint'(locked), 0);
        for (int i = 0; i < 24; i++) step(1, 0, 0);
        chk("t3_relock24", longint'(locked), 0);
        chk("t3_held_bc", longint'(bit_count), 8);
        step(1, 0, 0);
        chk("t3_relock25", longint'(locked), 1);
        chk("t3_held_ec", longint'(err_count), 8);
`else
        chk("t3_still_locked", longint'(locked), 1);
        for (int i = 0; i < 25; i++) step(1, 0, 0);
        chk("t3_bc_after", longint'(bit_count), 33);
        chk("t3_ec_after", longint'(err_count), 8);
`endif
        $display("t3 eight flips: locked=%0d bit_count=%0d err_count=%0d", locked, bit_count, err_count);

        // Test 4: random enable gaps, same result as test 1.
        do_reset();
        n = 0;
        while (n < 1025) begin
            if ($urandom_range(1, 0) == 1) begin
                step(1, 0, 0);
                n++;
            end else begin
                step(0, 0, 0);
            end
        end
        chk("t4_bit_count", longint'(bit_count), 1000);
        chk("t4_err_count", longint'(err_count), 0);
        $display("t4 gapped enable: bit_count=%0d err_count=%0d", bit_count, err_count);

        // Random soak: gaps, sparse flips and occasional clears.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(3, 0) != 0, $urandom_range(49, 0) == 0, $urandom_range(299, 0) == 0);
        $display("soak: bit_count=%0d err_count=%0d locked=%0d", bit_count, err_count, locked);

        cmp_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
